// File: rtl/fir_cfg_sequencer.sv
//------------------------------------------------------------------------------
// fir_cfg_sequencer
//
// AXI-Lite master that programs and launches the fir block without host help.
// A sequence writes data_length to 0x10, writes every tap coefficient, reads
// each tap back and compares it, writes ap_start, then polls ap_control until
// ap_done is seen or the poll budget runs out.
//
// Ports
//   axis_clk, axis_rst       clock, asynchronous active-high reset
//   start                    one-cycle pulse, accepted only in IDLE
//   data_length              value written to 0x10, latched on accepted start
//   coef_idx / coef_data     tap lookup: index out, coefficient back (comb.)
//   busy, done               sequence in progress / one-cycle end pulse
//   error, err_code, err_idx sticky status: 1 = tap mismatch, 2 = poll timeout
//   aw*, w*, ar*, r*         AXI-Lite master channels (no B channel on fir)
//------------------------------------------------------------------------------
module fir_cfg_sequencer #(
    parameter int                     pADDR_WIDTH = 12,
    parameter int                     pDATA_WIDTH = 32,
    parameter int                     Tape_Num    = 11,
    parameter logic [pADDR_WIDTH-1:0] pTAP_BASE   = 12'h20,
    parameter int                     pTAP_STRIDE = 4,
    parameter int                     pPOLL_GAP   = 8,
    parameter int                     pPOLL_MAX   = 65535
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   start,
    input  logic [pDATA_WIDTH-1:0] data_length,
    output logic [3:0]             coef_idx,
    input  logic [pDATA_WIDTH-1:0] coef_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code,
    output logic [3:0]             err_idx,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    output logic                   rready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata
);

    localparam int POLL_W = $clog2(pPOLL_MAX + 1);
    localparam int GAP_W  = $clog2(pPOLL_GAP + 1);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'('h10);

    typedef enum logic [2:0] {
        IDLE, WR_LEN, WR_TAP, RD_TAP, WR_START, POLL_WAIT, POLL_RD, FIN
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    state_t                 state_q,    state_d;
    logic                   txn_q,      txn_d;      // a transaction is in flight
    logic                   aw_ok_q,    aw_ok_d;    // AW handshake already done
    logic                   w_ok_q,     w_ok_d;     // W handshake already done
    logic [3:0]             tap_k_q,    tap_k_d;
    logic [GAP_W-1:0]       gap_cnt_q,  gap_cnt_d;
    logic [POLL_W-1:0]      poll_cnt_q, poll_cnt_d;
    logic [pDATA_WIDTH-1:0] len_q,      len_d;
    logic                   awvalid_q,  awvalid_d;
    logic [pADDR_WIDTH-1:0] awaddr_q,   awaddr_d;
    logic                   wvalid_q,   wvalid_d;
    logic [pDATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic                   arvalid_q,  arvalid_d;
    logic [pADDR_WIDTH-1:0] araddr_q,   araddr_d;
    logic                   rready_q,   rready_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic                   error_q,    error_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [3:0]             err_idx_q,  err_idx_d;
    logic [3:0]             coef_idx_q, coef_idx_d;

    // Handshakes are formed only from registered valids, so no ready input
    // ever reaches a valid output combinationally.
    logic                   aw_hs, w_hs, ar_hs, r_hs, wr_fire, last_tap;
    logic [POLL_W-1:0]      poll_next;
    logic [pADDR_WIDTH-1:0] tap_addr;

    assign aw_hs     = awvalid_q & awready;
    assign w_hs      = wvalid_q & wready;
    assign ar_hs     = arvalid_q & arready;
    assign r_hs      = rready_q & rvalid;
    // Both channels may finish in either order or together.
    assign wr_fire   = txn_q & (aw_ok_q | aw_hs) & (w_ok_q | w_hs);
    assign last_tap  = (tap_k_q == 4'(Tape_Num - 1));
    assign poll_next = poll_cnt_q + POLL_W'(1);
    assign tap_addr  = pTAP_BASE + pADDR_WIDTH'(tap_k_q) * pADDR_WIDTH'(pTAP_STRIDE);

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so
        // no path through the case below can leave a signal unassigned (latch).
        state_d    = state_q;
        txn_d      = txn_q;
        aw_ok_d    = aw_ok_q;
        w_ok_d     = w_ok_q;
        tap_k_d    = tap_k_q;
        gap_cnt_d  = gap_cnt_q;
        poll_cnt_d = poll_cnt_q;
        len_d      = len_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        wvalid_d   = wvalid_q;
        wdata_d    = wdata_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        rready_d   = rready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;

        // Channel bookkeeping shared by every state: each valid drops on the
        // cycle after its own handshake; rready follows the AR handshake.
        if (aw_hs) begin
            awvalid_d = 1'b0;
            aw_ok_d   = 1'b1;
        end
        if (w_hs) begin
            wvalid_d = 1'b0;
            w_ok_d   = 1'b1;
        end
        if (ar_hs) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
        end
        if (r_hs) begin
            rready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = data_length;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    err_idx_d  = 4'd0;
                    busy_d     = 1'b1;
                    tap_k_d    = 4'd0;
                    poll_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = WR_LEN;
                end
            end

            WR_LEN: begin
                if (!txn_q) begin
                    txn_d     = 1'b1;
                    aw_ok_d   = 1'b0;
                    w_ok_d    = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = ADDR_LEN;
                    wdata_d   = len_q;
                end else if (wr_fire) begin
                    txn_d   = 1'b0;
                    tap_k_d = 4'd0;
                    state_d = WR_TAP;
                end
            end

            WR_TAP: begin
                // coef_idx already equals tap_k here, so coef_data is valid.
                if (!txn_q) begin
                    txn_d     = 1'b1;
                    aw_ok_d   = 1'b0;
                    w_ok_d    = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = tap_addr;
                    wdata_d   = coef_data;
                end else if (wr_fire) begin
                    txn_d = 1'b0;
                    if (last_tap) begin
                        tap_k_d = 4'd0;
                        state_d = RD_TAP;
                    end else begin
                        tap_k_d = tap_k_q + 4'd1;
                    end
                end
            end

            RD_TAP: begin
                if (!txn_q) begin
                    txn_d     = 1'b1;
                    arvalid_d = 1'b1;
                    araddr_d  = tap_addr;
                end else if (r_hs) begin
                    txn_d = 1'b0;
                    // Keep checking after a mismatch; only the first is recorded.
                    if (rdata != coef_data) begin
                        error_d = 1'b1;
                        if (!error_q) begin
                            err_code_d = ERR_MISMATCH;
                            err_idx_d  = tap_k_q;
                        end
                    end
                    if (last_tap) begin
                        tap_k_d = 4'd0;
                        if (error_q || (rdata != coef_data)) begin
                            done_d  = 1'b1;
                            state_d = FIN;
                        end else begin
                            state_d = WR_START;
                        end
                    end else begin
                        tap_k_d = tap_k_q + 4'd1;
                    end
                end
            end

            WR_START: begin
                if (!txn_q) begin
                    txn_d     = 1'b1;
                    aw_ok_d   = 1'b0;
                    w_ok_d    = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = ADDR_CTRL;
                    wdata_d   = pDATA_WIDTH'(1);
                end else if (wr_fire) begin
                    txn_d     = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = POLL_WAIT;
                end
            end

            POLL_WAIT: begin
                if (gap_cnt_q == GAP_W'(pPOLL_GAP - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = POLL_RD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            POLL_RD: begin
                if (!txn_q) begin
                    txn_d     = 1'b1;
                    arvalid_d = 1'b1;
                    araddr_d  = ADDR_CTRL;
                end else if (r_hs) begin
                    txn_d      = 1'b0;
                    poll_cnt_d = poll_next;
                    if (rdata[1]) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else if (poll_next == POLL_W'(pPOLL_MAX)) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        done_d     = 1'b1;
                        state_d    = FIN;
                    end else begin
                        state_d = POLL_WAIT;
                    end
                end
            end

            FIN: begin
                // done is high during this cycle; a start seen now is dropped
                // because only IDLE accepts it.
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        coef_idx_d = tap_k_d;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q    <= IDLE;
            txn_q      <= 1'b0;
            aw_ok_q    <= 1'b0;
            w_ok_q     <= 1'b0;
            tap_k_q    <= 4'd0;
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
            len_q      <= '0;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            wvalid_q   <= 1'b0;
            wdata_q    <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            rready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            err_idx_q  <= 4'd0;
            coef_idx_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            aw_ok_q    <= aw_ok_d;
            w_ok_q     <= w_ok_d;
            tap_k_q    <= tap_k_d;
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            len_q      <= len_d;
            awvalid_q  <= awvalid_d;
            awaddr_q   <= awaddr_d;
            wvalid_q   <= wvalid_d;
            wdata_q    <= wdata_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            rready_q   <= rready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
            coef_idx_q <= coef_idx_d;
        end
    end

    assign awvalid  = awvalid_q;
    assign awaddr   = awaddr_q;
    assign wvalid   = wvalid_q;
    assign wdata    = wdata_q;
    assign arvalid  = arvalid_q;
    assign araddr   = araddr_q;
    assign rready   = rready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign err_idx  = err_idx_q;
    assign coef_idx = coef_idx_q;

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
//------------------------------------------------------------------------------
// tb_fir_cfg_sequencer
//
// Directed bench: an AXI-Lite slave model answers on the falling edge, logs
// every completed write/read, and a table of hand-derived transactions is
// compared against that log for each sequence.
//------------------------------------------------------------------------------
module tb_fir_cfg_sequencer;

    localparam int POLL_GAP = 8;
    localparam int POLL_MAX = 4;
    localparam int LOG_MAX  = 64;

    logic        axis_clk;
    logic        axis_rst;
    logic        start;
    logic [31:0] data_length;
    logic [3:0]  coef_idx;
    logic [31:0] coef_data;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [3:0]  err_idx;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rready, rvalid;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;

    fir_cfg_sequencer #(
        .pPOLL_GAP (POLL_GAP),
        .pPOLL_MAX (POLL_MAX)
    ) dut (
        .axis_clk    (axis_clk),
        .axis_rst    (axis_rst),
        .start       (start),
        .data_length (data_length),
        .coef_idx    (coef_idx),
        .coef_data   (coef_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .err_idx     (err_idx),
        .awvalid     (awvalid),
        .awaddr      (awaddr),
        .awready     (awready),
        .wvalid      (wvalid),
        .wdata       (wdata),
        .wready      (wready),
        .arvalid     (arvalid),
        .araddr      (araddr),
        .arready     (arready),
        .rready      (rready),
        .rvalid      (rvalid),
        .rdata       (rdata)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int cyc = 0;
    always @(posedge axis_clk) cyc <= cyc + 1;

    // Coefficient source
    int          taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    logic [31:0] coef_rom [16];
    assign coef_data = coef_rom[coef_idx];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave configuration and observation
    int          aw_stall = 0, w_stall = 0, bad_tap = -1, done_after = 3;
    int          rd0_cnt = 0, wr0_cnt = 0, wr10_cnt = 0;
    int          rd0_cyc [8];
    int          log_n = 0;
    bit          log_wr   [LOG_MAX];
    logic [11:0] log_addr [LOG_MAX];
    logic [31:0] log_data [LOG_MAX];
    logic [31:0] mem [16];

    task automatic log_txn(input bit is_wr, input logic [11:0] a, input logic [31:0] d);
        if (log_n < LOG_MAX) begin
            log_wr[log_n]   = is_wr;
            log_addr[log_n] = a;
            log_data[log_n] = d;
        end
        log_n++;
    endtask

    // AXI-Lite slave model: acts on the falling edge, so its ready/valid are
    // stable at the rising edge where the DUT samples them.
    initial begin : slave
        int          aw_wait, w_wait, idx;
        bit          aw_seen, w_seen, aw_have, w_have, r_pend;
        logic [11:0] aw_addr_l, ar_addr_l;
        logic [31:0] w_data_l, rd_val;
        aw_wait = 0; w_wait = 0; aw_seen = 0; w_seen = 0;
        aw_have = 0; w_have = 0; r_pend = 0;
        aw_addr_l = '0; ar_addr_l = '0; w_data_l = '0;
        awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
        forever begin
            @(negedge axis_clk);
            if (axis_rst) begin
                awready = 0; wready = 0; arready = 0; rvalid = 0;
                aw_wait = 0; w_wait = 0; aw_seen = 0; w_seen = 0;
                aw_have = 0; w_have = 0; r_pend = 0;
                continue;
            end
            // AW
            if (awready) begin
                check("aw_drop", {31'd0, awvalid}, 32'd0);
                awready = 0;
            end else if (awvalid) begin
                if (aw_seen) check("aw_stable", {20'd0, awaddr}, {20'd0, aw_addr_l});
                else aw_addr_l = awaddr;
                aw_seen = 1;
                if (aw_wait >= aw_stall) begin
                    awready = 1; aw_have = 1; aw_seen = 0; aw_wait = 0;
                end else aw_wait++;
            end
            // W
            if (wready) begin
                check("w_drop", {31'd0, wvalid}, 32'd0);
                wready = 0;
            end else if (wvalid) begin
                if (w_seen) check("w_stable", wdata, w_data_l);
                else w_data_l = wdata;
                w_seen = 1;
                if (w_wait >= w_stall) begin
                    wready = 1; w_have = 1; w_seen = 0; w_wait = 0;
                end else w_wait++;
            end
            if (aw_have && w_have) begin
                aw_have = 0; w_have = 0;
                log_txn(1'b1, aw_addr_l, w_data_l);
                if (aw_addr_l == 12'h000) wr0_cnt++;
                if (aw_addr_l == 12'h010) wr10_cnt++;
                if (aw_addr_l >= 12'h020 && aw_addr_l <= 12'h05c)
                    mem[(int'(aw_addr_l) - 32) / 4] = w_data_l;
            end
            // AR
            if (arready) begin
                check("ar_drop", {31'd0, arvalid}, 32'd0);
                arready = 0;
            end else if (arvalid && !r_pend) begin
                arready = 1; ar_addr_l = araddr; r_pend = 1;
                if (araddr == 12'h000 && rd0_cnt < 8) rd0_cyc[rd0_cnt] = cyc;
            end
            // R
            if (rvalid) begin
                check("r_drop", {31'd0, rready}, 32'd0);
                rvalid = 0;
            end else if (r_pend && rready) begin
                if (ar_addr_l == 12'h000) begin
                    rd0_cnt++;
                    rd_val = (done_after != 0 && rd0_cnt >= done_after) ? 32'h2 : 32'h0;
                end else begin
                    idx = (int'(ar_addr_l) - 32) / 4;
                    rd_val = (idx == bad_tap) ? 32'd99 : mem[idx[3:0]];
                end
                rvalid = 1; rdata = rd_val; r_pend = 0;
                log_txn(1'b0, ar_addr_l, rd_val);
            end
        end
    end

    task automatic clear_obs();
        log_n = 0; rd0_cnt = 0; wr0_cnt = 0; wr10_cnt = 0;
    endtask

    // Starts a sequence and waits for done. poke also pulses start mid-run
    // and again on the done cycle; both must be ignored.
    task automatic run(input logic [31:0] len, input bit poke, input string tag);
        int n;
        bit seen, busy_ok;
        clear_obs();
        @(negedge axis_clk);
        data_length = len; start = 1;
        @(negedge axis_clk);
        start = 0; data_length = 32'hdead_beef;
        check({tag, "_err_clr"}, {31'd0, error}, 32'd0);
        check({tag, "_busy_set"}, {31'd0, busy}, 32'd1);
        n = 0; seen = 0; busy_ok = 1;
        while (!seen && n < 3000) begin
            if (!busy) busy_ok = 0;
            if (done) begin
                seen = 1;
                if (poke) start = 1;
            end else begin
                start = poke && (n == 30);
                @(negedge axis_clk);
                n++;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        @(negedge axis_clk);
        start = 0;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
    endtask

    // Hand-derived clean sequence: 0x10<-600, 11 tap writes, 11 readbacks,
    // 0x00<-1, three polls with ap_done on the third.
    task automatic check_clean_log(input string tag);
        bit          ew;
        logic [11:0] ea;
        logic [31:0] ed;
        check({tag, "_txn_count"}, log_n, 27);
        check({tag, "_wr10_once"}, wr10_cnt, 1);
        for (int i = 0; i < 27 && i < log_n; i++) begin
            if (i == 0) begin
                ew = 1; ea = 12'h010; ed = 32'd600;
            end else if (i <= 11) begin
                ew = 1; ea = 12'h020 + 12'(4 * (i - 1)); ed = taps[i - 1];
            end else if (i <= 22) begin
                ew = 0; ea = 12'h020 + 12'(4 * (i - 12)); ed = taps[i - 12];
            end else if (i == 23) begin
                ew = 1; ea = 12'h000; ed = 32'd1;
            end else begin
                ew = 0; ea = 12'h000; ed = (i == 26) ? 32'd2 : 32'd0;
            end
            check($sformatf("%s_kind%0d", tag, i), {31'd0, log_wr[i]}, {31'd0, ew});
            check($sformatf("%s_addr%0d", tag, i), {20'd0, log_addr[i]}, {20'd0, ea});
            check($sformatf("%s_data%0d", tag, i), log_data[i], ed);
        end
        check({tag, "_last_tap_addr"}, {20'd0, log_addr[11]}, 32'h48);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    endtask

    initial begin : stim
        bit found;
        int log_hold;
        for (int i = 0; i < 16; i++) begin
            coef_rom[i] = (i < 11) ? taps[i] : 32'd0;
            mem[i] = '0;
        end
        axis_rst = 1; start = 0; data_length = '0;
        repeat (3) @(negedge axis_clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_error", {31'd0, error}, 0);
        check("rst_err_code", {30'd0, err_code}, 0);
        check("rst_err_idx", {28'd0, err_idx}, 0);
        check("rst_coef_idx", {28'd0, coef_idx}, 0);
        check("rst_valids", {28'd0, awvalid, wvalid, arvalid, rready}, 0);
        check("rst_awaddr", {20'd0, awaddr}, 0);
        check("rst_araddr", {20'd0, araddr}, 0);
        check("rst_wdata", wdata, 0);
        @(negedge axis_clk);
        #2 axis_rst = 0;

        // 1: zero-wait slave, ap_done on third poll
        run(32'd600, 1'b0, "t1");
        check_clean_log("t1");
        check("t1_polls", rd0_cnt, 3);

        // 2: stalled AW (4 cycles) and W (1 cycle)
        aw_stall = 4; w_stall = 1;
        run(32'd600, 1'b0, "t2");
        check_clean_log("t2");
        aw_stall = 0; w_stall = 0;

        // 3: tap 5 reads back as 99
        bad_tap = 5;
        run(32'd600, 1'b0, "t3");
        check("t3_error", {31'd0, error}, 1);
        check("t3_err_code", {30'd0, err_code}, 1);
        check("t3_err_idx", {28'd0, err_idx}, 5);
        check("t3_no_start_wr", wr0_cnt, 0);
        check("t3_no_poll", rd0_cnt, 0);
        check("t3_txn_count", log_n, 23);
        bad_tap = -1;

        // 4: ap_done never set, poll budget 4
        done_after = 0;
        run(32'd600, 1'b0, "t4");
        check("t4_polls", rd0_cnt, POLL_MAX);
        check("t4_error", {31'd0, error}, 1);
        check("t4_err_code", {30'd0, err_code}, 2);
        check("t4_txn_count", log_n, 28);
        for (int i = 1; i < POLL_MAX; i++)
            check($sformatf("t4_gap%0d", i), {31'd0, (rd0_cyc[i] - rd0_cyc[i - 1]) >= POLL_GAP}, 1);
        done_after = 3;

        // 6: start while busy and on the done cycle are ignored; error cleared
        run(32'd600, 1'b1, "t6");
        check_clean_log("t6");
        log_hold = log_n;
        repeat (6) @(negedge axis_clk);
        check("t6_idle_busy", {31'd0, busy}, 0);
        check("t6_no_new_txn", log_n, log_hold);
        run(32'd600, 1'b0, "t6b");
        check_clean_log("t6b");

        // 5: reset during tap-3 write with awvalid high
        clear_obs();
        @(negedge axis_clk);
        data_length = 32'd600; start = 1;
        @(negedge axis_clk);
        start = 0;
        found = 0;
        for (int n = 0; n < 500 && !found; n++) begin
            if (awvalid && awaddr == 12'h02c) found = 1;
            else @(negedge axis_clk);
        end
        check("t5_found_k3", {31'd0, found}, 1);
        check("t5_wdata_k3", wdata, 32'd23);
        #2 axis_rst = 1;
        #1;
        check("t5_valids_drop", {28'd0, awvalid, wvalid, arvalid, rready}, 0);
        check("t5_busy_drop", {31'd0, busy}, 0);
        check("t5_coef_idx", {28'd0, coef_idx}, 0);
        @(negedge axis_clk);
        #2 axis_rst = 0;
        run(32'd600, 1'b0, "t5");
        check_clean_log("t5");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
